lfsr_crc: RTL and testbench



---
 rtl/lfsr_crc.sv | 154 +++++++++++++++
 tb/tb_lfsr_crc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crc.sv
// lfsr_crc: parameterizable CRC generator that advances an LFSR by DATA_WIDTH
// serial steps per accepted word. The next state of every register bit is an
// XOR over the current state and the incoming word. The per-bit XOR masks are
// derived at elaboration time by running the serial recurrence symbolically.
module lfsr_crc #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT    = {LFSR_WIDTH{1'b1}},
    parameter string                 LFSR_CONFIG  = "FIBONACCI",
    parameter bit                    REVERSE      = 1'b0,
    parameter bit                    INVERT       = 1'b1,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    OUTPUT_WIDTH = LFSR_WIDTH,
    parameter string                 STYLE        = "AUTO"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_in_valid,
    output logic [OUTPUT_WIDTH-1:0] crc_out
);

    localparam int W  = LFSR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int MW = W + DW;   // mask row: bits [W-1:0] state, [MW-1:W] data

    localparam bit GALOIS   = (LFSR_CONFIG == "GALOIS");
    localparam bit USE_LOOP = (STYLE == "LOOP");

    // Reject unsupported configurations while elaborating.
    if (LFSR_CONFIG != "GALOIS" && LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
        $error("lfsr_crc: LFSR_CONFIG must be GALOIS or FIBONACCI");
    end
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
        $error("lfsr_crc: STYLE must be AUTO, LOOP or REDUCTION");
    end
    if (OUTPUT_WIDTH > LFSR_WIDTH || OUTPUT_WIDTH < 1) begin : g_bad_out
        $error("lfsr_crc: OUTPUT_WIDTH must be in 1..LFSR_WIDTH");
    end
    if (LFSR_WIDTH < 2 || LFSR_WIDTH > 64) begin : g_bad_width
        $error("lfsr_crc: LFSR_WIDTH must be in 2..64");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_data
        $error("lfsr_crc: DATA_WIDTH must be in 1..256");
    end

    typedef logic [MW-1:0]  row_t;
    typedef row_t [W-1:0]   mat_t;

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // In the reflected form the taps are mirrored so the register shifts right.
    localparam logic [W-1:0] TAPS = REVERSE ? bitrev(LFSR_POLY) : LFSR_POLY;

    // Symbolic serial simulation: each row tracks which state/data bits are
    // XORed into that register bit after DW steps.
    function automatic mat_t calc_mask();
        mat_t cur;
        mat_t nxt;
        row_t fb;
        row_t din;
        int   d;
        for (int i = 0; i < W; i++) begin
            cur[i]    = '0;
            cur[i][i] = 1'b1;
        end
        for (int k = 0; k < DW; k++) begin
            d         = REVERSE ? k : DW - 1 - k;
            din       = '0;
            din[W+d]  = 1'b1;
            if (GALOIS) begin
                if (REVERSE) begin
                    fb = din ^ cur[0];
                    for (int i = 0; i < W - 1; i++) nxt[i] = cur[i+1] ^ (TAPS[i] ? fb : '0);
                    nxt[W-1] = TAPS[W-1] ? fb : '0;
                end else begin
                    fb = din ^ cur[W-1];
                    nxt[0] = TAPS[0] ? fb : '0;
                    for (int i = 1; i < W; i++) nxt[i] = cur[i-1] ^ (TAPS[i] ? fb : '0);
                end
            end else begin
                fb = din;
                for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ cur[i];
                if (REVERSE) begin
                    for (int i = 0; i < W - 1; i++) nxt[i] = cur[i+1];
                    nxt[W-1] = fb;
                end else begin
                    nxt[0] = fb;
                    for (int i = 1; i < W; i++) nxt[i] = cur[i-1];
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    logic [W-1:0] state;
    logic [W-1:0] next_state;
    logic [W-1:0] out_full;

    if (USE_LOOP) begin : g_loop
        logic [W-1:0] s;
        logic         fbb;
        // Direct unroll of the serial recurrence on live values.
        always_comb begin
            s   = state;
            fbb = 1'b0;
            for (int k = 0; k < DW; k++) begin
                if (GALOIS) begin
                    if (REVERSE) begin
                        fbb = s[0] ^ data_in[k];
                        s   = (s >> 1) ^ (fbb ? TAPS : '0);
                    end else begin
                        fbb = s[W-1] ^ data_in[DW-1-k];
                        s   = (s << 1) ^ (fbb ? TAPS : '0);
                    end
                end else begin
                    if (REVERSE) begin
                        fbb = data_in[k] ^ (^(s & TAPS));
                        s   = {fbb, s[W-1:1]};
                    end else begin
                        fbb = data_in[DW-1-k] ^ (^(s & TAPS));
                        s   = {s[W-2:0], fbb};
                    end
                end
            end
            next_state = s;
        end
    end else begin : g_reduction
        localparam mat_t MASK = calc_mask();
        logic [MW-1:0] vec;
        assign vec = {data_in, state};
        for (genvar j = 0; j < W; j++) begin : g_bit
            assign next_state[j] = ^(vec & MASK[j]);
        end
    end

    // State register: async reload of the init value, advance on valid words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_INIT;
        end else if (data_in_valid) begin
            state <= next_state;
        end
    end

    assign out_full = INVERT ? ~state : state;
    assign crc_out  = out_full[OUTPUT_WIDTH-1:0];

endmodule

// File: tb/tb_lfsr_crc.sv
// tb_lfsr_crc: directed checks of lfsr_crc against known CRC check values and
// small serial reference models.
module tb_lfsr_crc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data8 = '0;
    logic        valid8 = 1'b0;
    logic [31:0] data32 = '0;
    logic        valid32 = 1'b0;
    logic [63:0] data64 = '0;
    logic        valid64 = 1'b0;

    logic [31:0] crc8a, crc8l, crc32r, crc32l, crc64a;
    logic [15:0] crc16, crcfib, crcfibr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msg [0:63];

    always #5 clk = ~clk;

    lfsr_crc #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_INIT(32'hFFFFFFFF),
               .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1), .DATA_WIDTH(8),
               .OUTPUT_WIDTH(32), .STYLE("AUTO"))
        u8a (.clk(clk), .rst(rst), .data_in(data8), .data_in_valid(valid8), .crc_out(crc8a));

    lfsr_crc #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_INIT(32'hFFFFFFFF),
               .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1), .DATA_WIDTH(8),
               .OUTPUT_WIDTH(32), .STYLE("LOOP"))
        u8l (.clk(clk), .rst(rst), .data_in(data8), .data_in_valid(valid8), .crc_out(crc8l));

    lfsr_crc #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_INIT(32'hFFFFFFFF),
               .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1), .DATA_WIDTH(32),
               .OUTPUT_WIDTH(32), .STYLE("REDUCTION"))
        u32r (.clk(clk), .rst(rst), .data_in(data32), .data_in_valid(valid32), .crc_out(crc32r));

    lfsr_crc #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_INIT(32'hFFFFFFFF),
               .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1), .DATA_WIDTH(32),
               .OUTPUT_WIDTH(32), .STYLE("LOOP"))
        u32l (.clk(clk), .rst(rst), .data_in(data32), .data_in_valid(valid32), .crc_out(crc32l));

    lfsr_crc #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_INIT(32'hFFFFFFFF),
               .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1), .DATA_WIDTH(64),
               .OUTPUT_WIDTH(32), .STYLE("AUTO"))
        u64a (.clk(clk), .rst(rst), .data_in(data64), .data_in_valid(valid64), .crc_out(crc64a));

    lfsr_crc #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_INIT(16'hFFFF),
               .LFSR_CONFIG("GALOIS"), .REVERSE(1'b0), .INVERT(1'b0), .DATA_WIDTH(8),
               .OUTPUT_WIDTH(16), .STYLE("AUTO"))
        u16 (.clk(clk), .rst(rst), .data_in(data8), .data_in_valid(valid8), .crc_out(crc16));

    lfsr_crc #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_INIT(16'hFFFF),
               .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b0), .INVERT(1'b0), .DATA_WIDTH(8),
               .OUTPUT_WIDTH(16), .STYLE("AUTO"))
        ufib (.clk(clk), .rst(rst), .data_in(data8), .data_in_valid(valid8), .crc_out(crcfib));

    lfsr_crc #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_INIT(16'hFFFF),
               .LFSR_CONFIG("FIBONACCI"), .REVERSE(1'b1), .INVERT(1'b0), .DATA_WIDTH(8),
               .OUTPUT_WIDTH(16), .STYLE("LOOP"))
        ufibr (.clk(clk), .rst(rst), .data_in(data8), .data_in_valid(valid8), .crc_out(crcfibr));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 over msg[0..n-1], final complement applied.
    function automatic logic [31:0] crc32_ref(input int n);
        logic [31:0] s;
        logic        fb;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = s[0] ^ msg[i][k];
                s  = (s >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~s;
    endfunction

    // Bit-serial Fibonacci LFSR, poly 0x1021, init 0xFFFF, no inversion.
    function automatic logic [15:0] fib16_ref(input int n, input bit rev);
        logic [15:0] s;
        logic        fb;
        logic        d;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (rev) begin
                    d  = msg[i][k];
                    fb = d ^ (^(s & 16'h8408));
                    s  = {fb, s[15:1]};
                end else begin
                    d  = msg[i][7-k];
                    fb = d ^ (^(s & 16'h1021));
                    s  = {s[14:0], fb};
                end
            end
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        data8  = b;
        valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
    endtask

    task automatic load_check_string();
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    endtask

    initial begin
        int len;
        int gap;

        // Reset state
        tick();
        tick();
        check("rst_crc32_auto", 64'(crc8a), 64'h0);
        check("rst_crc32_loop", 64'(crc8l), 64'h0);
        check("rst_crc32_dw64", 64'(crc64a), 64'h0);
        check("rst_crc16", 64'(crc16), 64'hFFFF);
        rst = 1'b0;
        tick();
        check("idle_crc32", 64'(crc8a), 64'h0);

        // Mid-frame asynchronous reset
        load_check_string();
        for (int i = 0; i < 4; i++) send8(msg[i]);
        check("partial_crc32", 64'(crc8a), 64'(crc32_ref(4)));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_crc32", 64'(crc8a), 64'h0);
        check("async_rst_crc16", 64'(crc16), 64'hFFFF);
        tick();
        rst = 1'b0;

        // "123456789" back to back
        do_reset();
        for (int i = 0; i < 9; i++) begin
            data8  = msg[i];
            valid8 = 1'b1;
            tick();
        end
        valid8 = 1'b0;
        check("check_crc32_auto", 64'(crc8a), 64'hCBF43926);
        check("check_crc32_loop", 64'(crc8l), 64'hCBF43926);
        check("check_crc16_ccitt", 64'(crc16), 64'h29B1);
        check("check_fib16", 64'(crcfib), 64'(fib16_ref(9, 1'b0)));
        check("check_fib16_rev", 64'(crcfibr), 64'(fib16_ref(9, 1'b1)));

        // Same bytes with idle gaps carrying junk data
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send8(msg[i]);
            gap = 1 + $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                data8 = 8'($urandom);
                tick();
                check("gap_hold", 64'(crc8a), 64'(crc32_ref(i + 1)));
            end
        end
        check("gap_final_auto", 64'(crc8a), 64'hCBF43926);
        check("gap_final_loop", 64'(crc8l), 64'hCBF43926);

        // Single-byte messages
        do_reset();
        send8(8'h00);
        check("byte_00", 64'(crc8a), 64'hD202EF8D);
        do_reset();
        send8(8'h61);
        check("byte_61", 64'(crc8l), 64'hE8B7BE43);

        // Wide datapaths with random frames packed little-endian
        for (int f = 0; f < 4; f++) begin
            len = 8 * (1 + $urandom_range(0, 3));
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            do_reset();
            for (int w = 0; w < len / 4; w++) begin
                data32  = {msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]};
                valid32 = 1'b1;
                tick();
                valid32 = 1'b0;
                data32  = 32'($urandom);
                if (w % 2 == 1) tick();
            end
            check("dw32_reduction", 64'(crc32r), 64'(crc32_ref(len)));
            check("dw32_loop", 64'(crc32l), 64'(crc32_ref(len)));
            do_reset();
            for (int w = 0; w < len / 8; w++) begin
                for (int b = 0; b < 8; b++) data64[8*b +: 8] = msg[8*w+b];
                valid64 = 1'b1;
                tick();
            end
            valid64 = 1'b0;
            check("dw64_auto", 64'(crc64a), 64'(crc32_ref(len)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
